// File: rtl/ex_operand_forward_if.sv
// Bundle between the ID/EX pipeline registers and the EX operand-forwarding mux.
// Carries the hit flags, the candidate operand sources, pipeline control, and the forwarded operands.
interface ex_operand_forward_if #(
    parameter int XLEN = 32
);
    logic            hit_rs1_ldex_ex;
    logic            hit_rs1_idex_ex;
    logic            hit_rs1_idma_ex;
    logic            hit_rs1_idwb_ex;
    logic            nohit_rs1_ex;
    logic            hit_rs2_ldex_ex;
    logic            hit_rs2_idex_ex;
    logic            hit_rs2_idma_ex;
    logic            hit_rs2_idwb_ex;
    logic            nohit_rs2_ex;
    logic [XLEN-1:0] rs1_data_ex;
    logic [XLEN-1:0] rs2_data_ex;
    logic [XLEN-1:0] rd_data_ma;
    logic [XLEN-1:0] rd_data_wb;
    logic            stall;
    logic            rst_pipe;
    logic [XLEN-1:0] rs1_fwd_ex;
    logic [XLEN-1:0] rs2_fwd_ex;
    logic            ld_use_stall;

    modport master (
        output hit_rs1_ldex_ex, hit_rs1_idex_ex, hit_rs1_idma_ex, hit_rs1_idwb_ex, nohit_rs1_ex,
        output hit_rs2_ldex_ex, hit_rs2_idex_ex, hit_rs2_idma_ex, hit_rs2_idwb_ex, nohit_rs2_ex,
        output rs1_data_ex, rs2_data_ex, rd_data_ma, rd_data_wb, stall, rst_pipe,
        input  rs1_fwd_ex, rs2_fwd_ex, ld_use_stall
    );

    modport slave (
        input  hit_rs1_ldex_ex, hit_rs1_idex_ex, hit_rs1_idma_ex, hit_rs1_idwb_ex, nohit_rs1_ex,
        input  hit_rs2_ldex_ex, hit_rs2_idex_ex, hit_rs2_idma_ex, hit_rs2_idwb_ex, nohit_rs2_ex,
        input  rs1_data_ex, rs2_data_ex, rd_data_ma, rd_data_wb, stall, rst_pipe,
        output rs1_fwd_ex, rs2_fwd_ex, ld_use_stall
    );
endinterface

// File: rtl/ex_operand_forward.sv
// EX-stage operand forwarding mux with a one-cycle load-use interlock.
// Operand selection is replicated per source operand (index 0 = rs1, 1 = rs2).
module ex_operand_forward #(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    ex_operand_forward_if.slave bus
);
    typedef enum logic {
        IDLE   = 1'b0,
        LDWAIT = 1'b1
    } state_t;

    state_t          state_reg;
    state_t          state_next;
    logic [XLEN-1:0] wb_hold_reg;
    logic [XLEN-1:0] cap_reg  [2];
    logic [XLEN-1:0] rs_data  [2];
    logic [XLEN-1:0] idle_sel [2];
    logic [XLEN-1:0] fwd_sel  [2];
    logic [1:0]      hit_ldex;
    logic [1:0]      hit_idex;
    logic [1:0]      hit_idma;
    logic [1:0]      hit_idwb;
    logic            ld_use;
    logic            enter_ldwait;

    assign hit_ldex   = {bus.hit_rs2_ldex_ex, bus.hit_rs1_ldex_ex};
    assign hit_idex   = {bus.hit_rs2_idex_ex, bus.hit_rs1_idex_ex};
    assign hit_idma   = {bus.hit_rs2_idma_ex, bus.hit_rs1_idma_ex};
    assign hit_idwb   = {bus.hit_rs2_idwb_ex, bus.hit_rs1_idwb_ex};
    assign rs_data[0] = bus.rs1_data_ex;
    assign rs_data[1] = bus.rs2_data_ex;

    assign ld_use       = (state_reg == IDLE) && (|hit_ldex) && !bus.rst_pipe;
    assign enter_ldwait = ld_use && !bus.stall;

    // Flush outranks the freeze; a frozen pipeline holds whatever state it is in.
    always_comb begin
        state_next = state_reg;
        if (bus.rst_pipe) begin
            state_next = IDLE;
        end else if (!bus.stall) begin
            case (state_reg)
                IDLE:    state_next = ld_use ? LDWAIT : IDLE;
                LDWAIT:  state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // wb_hold tracks the value retired while the EX instruction sat in ID.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_hold_reg <= '0;
        end else if (!bus.stall && !ld_use) begin
            wb_hold_reg <= bus.rd_data_wb;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_operand
        // An ldex hit has no valid data yet; it shares the idex path as a don't-care.
        always_comb begin
            idle_sel[gi] = rs_data[gi];
            if (hit_ldex[gi] || hit_idex[gi]) begin
                idle_sel[gi] = bus.rd_data_ma;
            end else if (hit_idma[gi]) begin
                idle_sel[gi] = bus.rd_data_wb;
            end else if (hit_idwb[gi]) begin
                idle_sel[gi] = wb_hold_reg;
            end
        end

        // Snapshot operands on entry to LDWAIT: MA gets a bubble, so MA/WB move on.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cap_reg[gi] <= '0;
            end else if (bus.rst_pipe) begin
                cap_reg[gi] <= '0;
            end else if (enter_ldwait) begin
                cap_reg[gi] <= idle_sel[gi];
            end
        end

        always_comb begin
            fwd_sel[gi] = idle_sel[gi];
            if (state_reg == LDWAIT) begin
                fwd_sel[gi] = hit_ldex[gi] ? bus.rd_data_wb : cap_reg[gi];
            end
        end
    end

    assign bus.rs1_fwd_ex   = fwd_sel[0];
    assign bus.rs2_fwd_ex   = fwd_sel[1];
    assign bus.ld_use_stall = ld_use;
endmodule

// File: tb/tb_ex_operand_forward.sv
// Directed bench for ex_operand_forward: a table of combinational selection vectors
// followed by hand-written load-use, freeze, flush and reset sequences.
module tb_ex_operand_forward;
    localparam int XLEN = 32;

    // Flag field order: {ldex, idex, idma, idwb, nohit}
    localparam logic [4:0] F_NO   = 5'b00001;
    localparam logic [4:0] F_LD   = 5'b10000;
    localparam logic [4:0] F_EX   = 5'b01000;
    localparam logic [4:0] F_MA   = 5'b00100;
    localparam logic [4:0] F_WB   = 5'b00010;

    typedef struct {
        logic [4:0]  f1;
        logic [4:0]  f2;
        logic        flush;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] ma;
        logic [31:0] wb;
        logic [31:0] e1;
        logic [31:0] e2;
        logic        elus;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    vec_t vecs[10];

    ex_operand_forward_if #(.XLEN(XLEN)) bus ();

    ex_operand_forward #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic set_flags(input logic [4:0] f1, input logic [4:0] f2);
        {bus.hit_rs1_ldex_ex, bus.hit_rs1_idex_ex, bus.hit_rs1_idma_ex,
         bus.hit_rs1_idwb_ex, bus.nohit_rs1_ex} = f1;
        {bus.hit_rs2_ldex_ex, bus.hit_rs2_idex_ex, bus.hit_rs2_idma_ex,
         bus.hit_rs2_idwb_ex, bus.nohit_rs2_ex} = f2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        vecs[0] = '{F_NO,      F_NO,      1'b0, 32'h11, 32'h22, 32'hA, 32'hB, 32'h11, 32'h22, 1'b0};
        vecs[1] = '{F_EX|F_MA, F_NO,      1'b0, 32'h11, 32'h22, 32'hA, 32'hB, 32'hA,  32'h22, 1'b0};
        vecs[2] = '{F_MA,      F_NO,      1'b0, 32'h11, 32'h22, 32'hA, 32'hB, 32'hB,  32'h22, 1'b0};
        vecs[3] = '{F_WB,      F_NO,      1'b0, 32'h11, 32'h22, 32'hA, 32'hB, 32'h55, 32'h22, 1'b0};
        vecs[4] = '{F_NO,      F_EX,      1'b0, 32'h11, 32'h22, 32'hC, 32'hD, 32'h11, 32'hC,  1'b0};
        vecs[5] = '{F_NO,      F_MA|F_WB, 1'b0, 32'h11, 32'h22, 32'hC, 32'hD, 32'h11, 32'hD,  1'b0};
        vecs[6] = '{F_LD,      F_NO,      1'b0, 32'h33, 32'h44, 32'hE, 32'hF, 32'hE,  32'h44, 1'b1};
        vecs[7] = '{F_NO,      F_LD,      1'b0, 32'h33, 32'h44, 32'hE, 32'hF, 32'h33, 32'hE,  1'b1};
        vecs[8] = '{F_LD,      F_LD,      1'b1, 32'h33, 32'h44, 32'hE, 32'hF, 32'hE,  32'hE,  1'b0};
        vecs[9] = '{F_WB,      F_WB,      1'b0, 32'h33, 32'h44, 32'hE, 32'hF, 32'h55, 32'h55, 1'b0};

        // Reset state
        rst_n = 1'b0;
        set_flags(5'b0, 5'b0);
        bus.rs1_data_ex = 32'h31;
        bus.rs2_data_ex = 32'h42;
        bus.rd_data_ma  = 32'h0;
        bus.rd_data_wb  = 32'h0;
        bus.stall       = 1'b0;
        bus.rst_pipe    = 1'b0;
        #3;
        chk("reset_rs1_fwd", bus.rs1_fwd_ex, 32'h31);
        chk("reset_rs2_fwd", bus.rs2_fwd_ex, 32'h42);
        chk("reset_lus", 32'(bus.ld_use_stall), 32'h0);
        chk("reset_state", 32'(dut.state_reg), 32'h0);
        chk("reset_wb_hold", dut.wb_hold_reg, 32'h0);
        chk("reset_cap1", dut.cap_reg[0], 32'h0);
        #9;
        rst_n = 1'b1;
        tick();

        // Load wb_hold with 0x55, then freeze so the table sees a stable IDLE block
        set_flags(F_NO, F_NO);
        bus.rd_data_wb = 32'h55;
        tick();
        bus.stall = 1'b1;

        for (int i = 0; i < 10; i++) begin
            set_flags(vecs[i].f1, vecs[i].f2);
            bus.rst_pipe    = vecs[i].flush;
            bus.rs1_data_ex = vecs[i].rs1;
            bus.rs2_data_ex = vecs[i].rs2;
            bus.rd_data_ma  = vecs[i].ma;
            bus.rd_data_wb  = vecs[i].wb;
            #2;
            chk($sformatf("vec%0d_rs1_fwd", i), bus.rs1_fwd_ex, vecs[i].e1);
            chk($sformatf("vec%0d_rs2_fwd", i), bus.rs2_fwd_ex, vecs[i].e2);
            chk($sformatf("vec%0d_lus", i), 32'(bus.ld_use_stall), 32'(vecs[i].elus));
        end
        bus.rst_pipe = 1'b0;
        set_flags(F_NO, F_NO);
        tick();

        // idwb hold: the value retired on the previous edge is forwarded
        bus.stall       = 1'b0;
        bus.rs1_data_ex = 32'h11;
        bus.rs2_data_ex = 32'h22;
        bus.rd_data_wb  = 32'h55;
        tick();
        set_flags(F_NO, F_WB);
        bus.rd_data_wb = 32'h99;
        #1;
        chk("idwb_rs2_fwd", bus.rs2_fwd_ex, 32'h55);
        chk("idwb_rs1_fwd", bus.rs1_fwd_ex, 32'h11);

        // Load-use: cycle N stalls, cycle N+1 forwards the load data
        set_flags(F_NO, F_NO);
        bus.rd_data_wb = 32'h77;
        tick();
        set_flags(F_LD, F_EX);
        bus.rd_data_ma = 32'h7;
        bus.rd_data_wb = 32'h88;
        #1;
        chk("ldN_lus", 32'(bus.ld_use_stall), 32'h1);
        chk("ldN_state", 32'(dut.state_reg), 32'h0);
        tick();
        bus.rd_data_ma = 32'h1234;
        bus.rd_data_wb = 32'hCAFE;
        #1;
        chk("ldN1_state", 32'(dut.state_reg), 32'h1);
        chk("ldN1_rs1_fwd", bus.rs1_fwd_ex, 32'hCAFE);
        chk("ldN1_rs2_fwd", bus.rs2_fwd_ex, 32'h7);
        chk("ldN1_lus", 32'(bus.ld_use_stall), 32'h0);
        chk("ldN1_wb_hold", dut.wb_hold_reg, 32'h77);

        // External freeze while in LDWAIT
        bus.stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("frz%0d_state", k), 32'(dut.state_reg), 32'h1);
            chk($sformatf("frz%0d_rs1_fwd", k), bus.rs1_fwd_ex, 32'hCAFE);
            chk($sformatf("frz%0d_rs2_fwd", k), bus.rs2_fwd_ex, 32'h7);
            chk($sformatf("frz%0d_wb_hold", k), dut.wb_hold_reg, 32'h77);
        end
        bus.stall = 1'b0;
        tick();
        chk("unfrz_state", 32'(dut.state_reg), 32'h0);
        chk("unfrz_wb_hold", dut.wb_hold_reg, 32'hCAFE);
        set_flags(F_NO, F_NO);

        // Flush suppresses the stall request in IDLE
        set_flags(F_LD, F_NO);
        bus.rs2_data_ex = 32'h42;
        bus.rst_pipe    = 1'b1;
        #1;
        chk("flush_idle_lus", 32'(bus.ld_use_stall), 32'h0);
        tick();
        chk("flush_idle_state", 32'(dut.state_reg), 32'h0);
        bus.rst_pipe = 1'b0;
        #1;
        chk("ld_again_lus", 32'(bus.ld_use_stall), 32'h1);
        tick();
        chk("ld_again_state", 32'(dut.state_reg), 32'h1);
        chk("ld_again_cap2", dut.cap_reg[1], 32'h42);

        // Flush from LDWAIT clears the snapshots
        bus.rst_pipe = 1'b1;
        #1;
        chk("flush_ldw_lus", 32'(bus.ld_use_stall), 32'h0);
        tick();
        chk("flush_ldw_state", 32'(dut.state_reg), 32'h0);
        chk("flush_ldw_cap1", dut.cap_reg[0], 32'h0);
        chk("flush_ldw_cap2", dut.cap_reg[1], 32'h0);
        bus.rst_pipe = 1'b0;

        // Asynchronous reset in the middle of LDWAIT
        set_flags(F_LD, F_EX);
        bus.rd_data_ma = 32'h7;
        tick();
        chk("pre_rst_state", 32'(dut.state_reg), 32'h1);
        chk("pre_rst_cap2", dut.cap_reg[1], 32'h7);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_state", 32'(dut.state_reg), 32'h0);
        chk("arst_cap1", dut.cap_reg[0], 32'h0);
        chk("arst_cap2", dut.cap_reg[1], 32'h0);
        chk("arst_wb_hold", dut.wb_hold_reg, 32'h0);
        #2;
        rst_n = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
